// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - key gesture classifier (SINGLE/DOUBLE/LONG/REPEAT) with one-entry event buffer
//
// Sits behind the debounce filter. Turns debounced press/release edges into
// gesture events and hands them to the consumer through a one-entry
// valid/ready buffer.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         classifier enable; low holds the sequencer in IDLE
//   key_flag   one-cycle pulse on each debounced edge
//   key_state  debounced key level (0 = pressed)
//   evt_valid  buffer holds an event
//   evt_code   0 SINGLE, 1 DOUBLE, 2 LONG, 3 REPEAT
//   evt_ready  consumer accepts the buffered event this cycle
//   evt_ovf    one-cycle pulse when a new event was dropped on a full buffer

module key_event_ctrl #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned DCLICK_CYC = 15_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_ovf
);

    localparam logic [1:0] EV_SINGLE = 2'd0;
    localparam logic [1:0] EV_DOUBLE = 2'd1;
    localparam logic [1:0] EV_LONG   = 2'd2;
    localparam logic [1:0] EV_REPEAT = 2'd3;

    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LIM = CNT_W'(DCLICK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;
    logic             ovf_q, ovf_d;

    logic       press, release_evt;
    logic       emit;
    logic [1:0] emit_code;
    logic       load;

    assign press       = key_flag & ~key_state;
    assign release_evt = key_flag &  key_state;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = EV_SINGLE;

        case (state_q)
            S_IDLE: begin
                if (press) state_d = S_PRESS1;
            end
            S_PRESS1: begin
                cnt_d = cnt_q + 1'b1;
                // Release is checked first so a release on the limit cycle is a click, not LONG.
                if (release_evt) begin
                    state_d = S_WAIT2;
                end else if (cnt_q == LONG_LIM) begin
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                    state_d   = S_LONGH;
                end
            end
            S_WAIT2: begin
                cnt_d = cnt_q + 1'b1;
                // A second press on the timeout cycle still counts as a double click.
                if (press) begin
                    state_d = S_PRESS2;
                end else if (cnt_q == DCLICK_LIM) begin
                    emit      = 1'b1;
                    emit_code = EV_SINGLE;
                    state_d   = S_IDLE;
                end
            end
            S_PRESS2: begin
                if (release_evt) begin
                    emit      = 1'b1;
                    emit_code = EV_DOUBLE;
                    state_d   = S_IDLE;
                end
            end
            S_LONGH: begin
                cnt_d = cnt_q + 1'b1;
                if (release_evt) begin
                    state_d = S_IDLE;
                end else if (cnt_q == REPEAT_LIM) begin
                    emit      = 1'b1;
                    emit_code = EV_REPEAT;
                    cnt_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            emit    = 1'b0;
        end
    end

    // A slot being drained this cycle can take the new event without a bubble.
    assign load = emit & (~valid_q | evt_ready);

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = emit & valid_q & ~evt_ready;
        if (load) begin
            valid_d = 1'b1;
            code_d  = emit_code;
        end else if (valid_q & evt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - directed self-checking bench for key_event_ctrl

module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       key_flag;
    logic       key_state;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       evt_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int vcyc[$];
    int vcode[$];
    int ocyc[$];

    always #5 clk = ~clk;

    key_event_ctrl #(
        .LONG_CYC  (100),
        .REPEAT_CYC(20),
        .DCLICK_CYC(30),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .key_flag (key_flag),
        .key_state(key_state),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ready(evt_ready),
        .evt_ovf  (evt_ovf)
    );

    // Log every cycle in which an event is presented and every overflow pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid) begin
                vcyc.push_back(cyc);
                vcode.push_back(int'(evt_code));
            end
            if (evt_ovf) ocyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic start();
        rst       = 1'b1;
        en        = 1'b1;
        key_flag  = 1'b0;
        key_state = 1'b1;
        evt_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        vcyc.delete();
        vcode.delete();
        ocyc.delete();
    endtask

    task automatic press_at(input int n);
        goto(n);
        key_flag  = 1'b1;
        key_state = 1'b0;
        step();
        key_flag = 1'b0;
    endtask

    task automatic release_at(input int n);
        goto(n);
        key_flag  = 1'b1;
        key_state = 1'b1;
        step();
        key_flag = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c[5];
        int exp_k[5];
        int bad;

        // Reset state
        rst = 1'b1; en = 1'b1; key_flag = 1'b0; key_state = 1'b1; evt_ready = 1'b1;
        step();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_code",  int'(evt_code), 0);
        check("rst_ovf",   int'(evt_ovf), 0);

        // 1: single click
        start();
        press_at(10);
        release_at(20);
        goto(80);
        check("t1_count", vcyc.size(), 1);
        check("t1_cyc",   qget(vcyc, 0), 51);
        check("t1_code",  qget(vcode, 0), 0);
        check("t1_ovf",   ocyc.size(), 0);

        // 2: double click
        start();
        press_at(10);
        release_at(20);
        press_at(40);
        release_at(45);
        goto(100);
        check("t2_count", vcyc.size(), 1);
        check("t2_cyc",   qget(vcyc, 0), 46);
        check("t2_code",  qget(vcode, 0), 1);

        // 3: long press with repeats
        start();
        press_at(10);
        release_at(200);
        goto(260);
        exp_c = '{111, 131, 151, 171, 191};
        exp_k = '{2, 3, 3, 3, 3};
        check("t3_count", vcyc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_cyc%0d", i),  qget(vcyc, i),  exp_c[i]);
            check($sformatf("t3_code%0d", i), qget(vcode, i), exp_k[i]);
        end
        check("t3_ovf", ocyc.size(), 0);

        // 4a: release on the LONG limit cycle
        start();
        press_at(10);
        release_at(110);
        goto(180);
        check("t4a_count", vcyc.size(), 1);
        check("t4a_cyc",   qget(vcyc, 0), 141);
        check("t4a_code",  qget(vcode, 0), 0);

        // 4b: second press on the double-click timeout cycle
        start();
        press_at(10);
        release_at(20);
        press_at(50);
        release_at(55);
        goto(120);
        check("t4b_count", vcyc.size(), 1);
        check("t4b_cyc",   qget(vcyc, 0), 56);
        check("t4b_code",  qget(vcode, 0), 1);

        // 5: consumer stalled, repeats overflow
        start();
        evt_ready = 1'b0;
        press_at(10);
        goto(155);
        check("t5_first", qget(vcyc, 0), 111);
        check("t5_held",  vcyc.size(), 44);
        bad = 0;
        foreach (vcode[i]) if (vcode[i] != 2) bad++;
        check("t5_code_stable", bad, 0);
        check("t5_ovf_count", ocyc.size(), 2);
        check("t5_ovf0", qget(ocyc, 0), 131);
        check("t5_ovf1", qget(ocyc, 1), 151);
        evt_ready = 1'b1;
        release_at(156);
        goto(175);
        check("t5_after_accept", vcyc.size(), 45);
        check("t5_last", qget(vcyc, 44), 155);
        check("t5_ovf_final", ocyc.size(), 2);

        // 6: reset mid-gesture with a pending event, then disabled operation
        start();
        evt_ready = 1'b0;
        press_at(10);
        release_at(20);
        press_at(55);
        goto(60);
        check("t6_pending", int'(evt_valid), 1);
        rst = 1'b1;
        step();
        check("t6_rst_valid", int'(evt_valid), 0);
        check("t6_rst_code",  int'(evt_code), 0);
        check("t6_rst_ovf",   int'(evt_ovf), 0);
        check("t6_rst_state", int'(dut.state_q), 0);
        rst = 1'b0;
        en  = 1'b0;
        evt_ready = 1'b1;
        vcyc.delete();
        vcode.delete();
        ocyc.delete();
        release_at(70);
        press_at(80);
        release_at(90);
        press_at(100);
        goto(300);
        check("t6_en0_events", vcyc.size(), 0);
        check("t6_en0_ovf",    ocyc.size(), 0);
        check("t6_en0_state",  int'(dut.state_q), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sequencer downstream of the debounce filter.
- Consumes the filter's one-cycle key_flag pulse and its debounced key_state level (active-low key: 0 = pressed).
- Classifies each gesture as SINGLE, DOUBLE, LONG or REPEAT and hands it to the consumer (menu/UI logic) through a one-entry valid/ready buffer.
- Sequences the gesture timing that the filter itself does not track.

Parameters:
- LONG_CYC, 50_000_000, held cycles before a LONG event is emitted (1 s at 50 MHz).
- REPEAT_CYC, 10_000_000, cycles between REPEAT events while the key stays held after LONG.
- DCLICK_CYC, 15_000_000, window after the first release in which a second press makes a DOUBLE.
- CNT_W, 26, width of the timing counter; must hold max(LONG_CYC, REPEAT_CYC, DCLICK_CYC) - 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  classifier enable; low forces the FSM to IDLE.
- key_flag  in  1  one-cycle pulse from the debounce filter on each debounced edge.
- key_state  in  1  debounced key level; 0 = pressed, 1 = released.
- evt_valid  out  1  event buffer holds an event.
- evt_code  out  2  event type: 0 SINGLE, 1 DOUBLE, 2 LONG, 3 REPEAT.
- evt_ready  in  1  consumer accepts the event this cycle.
- evt_ovf  out  1  one-cycle pulse: a generated event was dropped because the buffer was full.

Behaviour:
- Decode: press = key_flag & ~key_state; release = key_flag & key_state. A press or release not expected in the current state is ignored.
- Reset values (rst=1 at a clk edge): state IDLE, cnt 0, evt_valid 0, evt_code 0, evt_ovf 0. Reset mid-gesture aborts it with no event; a pending buffered event is discarded.
- cnt increments by 1 every cycle in PRESS1, WAIT2 and LONGH. It clears to 0 on every state change and on every REPEAT emission. It never wraps, since each timed state exits at its limit.
- IDLE: on press, go to PRESS1.
- PRESS1:
  - release -> WAIT2.
  - Otherwise, when cnt == LONG_CYC-1: emit LONG and go to LONGH.
  - Release and LONG limit in the same cycle: release wins; no LONG.
- WAIT2:
  - press -> PRESS2.
  - Otherwise, when cnt == DCLICK_CYC-1: emit SINGLE and go to IDLE.
  - Press and timeout in the same cycle: press wins; result is DOUBLE.
- PRESS2: on release, emit DOUBLE and go to IDLE. No timeout; a held second press never becomes LONG.
- LONGH:
  - release -> IDLE, no event.
  - Otherwise, when cnt == REPEAT_CYC-1: emit REPEAT, clear cnt, stay in LONGH.
- en=0: next state IDLE and cnt 0; no event is emitted. The buffer and the handshake keep operating.
- Emission timing: an event emitted in cycle t appears as evt_valid/evt_code in cycle t+1 (registered).
- Buffer rules:
  - Empty, or accepted this cycle (evt_valid & evt_ready), when a new event is emitted: load it. evt_valid stays or goes to 1, so back-to-back events are possible with no bubble.
  - evt_valid & evt_ready with no new event: evt_valid goes to 0 next cycle.
  - evt_valid & ~evt_ready with a new event: keep the old event, drop the new one, pulse evt_ovf in cycle t+1.
  - evt_code is stable while evt_valid & ~evt_ready.
- Latency from the first flag cycle r (decode in cycle r, state change at the following edge):
  - SINGLE: evt_valid at r_release + DCLICK_CYC + 1.
  - LONG: evt_valid at r_press + LONG_CYC + 1.
  - DOUBLE: evt_valid at r_release2 + 1.

Test Plan:
Bench parameters: LONG_CYC=100, REPEAT_CYC=20, DCLICK_CYC=30; evt_ready=1 unless stated.
1. Press at cycle 10, release at cycle 20, no further flags -> evt_valid=1, evt_code=0 in cycle 51 only; evt_ovf never set.
2. Press at 10, release at 20, press at 40, release at 45 -> evt_code=1 valid in cycle 46 only; no SINGLE emitted.
3. Press at 10, hold to cycle 200, release -> LONG in cycle 111, REPEAT in cycles 131, 151, 171, 191; nothing after release.
4. Corner cases:
   - Release exactly in cycle 110, the cycle cnt hits 99 -> SINGLE at 141, no LONG.
   - Second press in the DCLICK timeout cycle -> DOUBLE, no SINGLE.
5. evt_ready=0; generate LONG and then REPEATs -> evt_code=2 stays held; evt_ovf pulses once per dropped REPEAT (cycles 131, 151). Raise evt_ready -> LONG accepted, evt_valid drops.
6. rst=1 at cycle 60 of a held press, then en=0 with presses applied -> state IDLE; evt_valid, evt_code and evt_ovf all 0; no events while en=0.
